// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between a pipelined req/gnt bus master and a boot loader write port.
// Optional bus write lock with error responses: define SRAM_ARB_WR_LOCK_EN.
module sram_port_arbiter #(
  parameter int unsigned AW          = 13,
  parameter int unsigned DW          = 32,
  parameter int unsigned RdLatency   = 1,
  parameter int unsigned Outstanding = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            loader_en_i,
  input  logic            loader_we_i,
  input  logic [AW-1:0]   loader_addr_i,
  input  logic [DW-1:0]   loader_wdata_i,
  input  logic            bus_req_i,
  output logic            bus_gnt_o,
  input  logic            bus_we_i,
  input  logic [AW-1:0]   bus_addr_i,
  input  logic [DW-1:0]   bus_wdata_i,
  input  logic [DW/8-1:0] bus_be_i,
  output logic            bus_rvalid_o,
  input  logic            bus_rready_i,
  output logic [DW-1:0]   bus_rdata_o,
  input  logic            lock_i,
  output logic            bus_rerr_o,
  output logic            csb_o,
  output logic            we_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] wmask_o,
  input  logic [DW-1:0]   rdata_i
);

  localparam int unsigned CntW = $clog2(Outstanding + 1);
  localparam int unsigned PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            gnt, pop, locked;

  assign gnt       = ~loader_en_i & bus_req_i & (cnt_q < CntW'(Outstanding));
  assign bus_gnt_o = gnt;

`ifdef SRAM_ARB_WR_LOCK_EN
  assign locked = bus_we_i & lock_i;
`else
  logic unused_lock;
  assign unused_lock = lock_i;
  assign locked      = 1'b0;
`endif

  // SRAM pins are driven straight from this cycle's winner; no access is ever deferred.
  always_comb begin
    csb_o   = 1'b1;
    we_o    = 1'b1;
    addr_o  = '0;
    wdata_o = '0;
    wmask_o = '0;
    if (loader_en_i) begin
      if (loader_we_i) begin
        csb_o   = 1'b0;
        we_o    = 1'b0;
        addr_o  = loader_addr_i;
        wdata_o = loader_wdata_i;
        wmask_o = '1;
      end
    end else if (gnt && !locked) begin
      csb_o   = 1'b0;
      we_o    = ~bus_we_i;
      addr_o  = bus_addr_i;
      wdata_o = bus_wdata_i;
      wmask_o = bus_be_i;
    end
  end

  // Credit counter: accepted requests whose response has not yet been popped.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!gnt && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Latency pipeline tracking which cycle the SRAM read data becomes valid.
  logic [RdLatency-1:0] pipe_vld_q, pipe_we_q;
  logic                 exit_vld, exit_we, exit_err;
  logic [DW-1:0]        exit_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      pipe_we_q  <= '0;
    end else begin
      pipe_vld_q[0] <= gnt;
      pipe_we_q[0]  <= gnt & bus_we_i;
      for (int i = 1; i < RdLatency; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_we_q[i]  <= pipe_we_q[i-1];
      end
    end
  end

`ifdef SRAM_ARB_WR_LOCK_EN
  logic [RdLatency-1:0] pipe_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_err_q <= '0;
    end else begin
      pipe_err_q[0] <= gnt & locked;
      for (int i = 1; i < RdLatency; i++) begin
        pipe_err_q[i] <= pipe_err_q[i-1];
      end
    end
  end

  assign exit_err = pipe_err_q[RdLatency-1];
`else
  assign exit_err = 1'b0;
`endif

  assign exit_vld  = pipe_vld_q[RdLatency-1];
  assign exit_we   = pipe_we_q[RdLatency-1];
  assign exit_data = exit_we ? '0 : rdata_i;

  // Response FIFO; the exit stage falls through when the FIFO is empty so that
  // grant-to-rvalid equals the SRAM read latency.
  logic [DW-1:0]   fifo_data_q [Outstanding];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] fcnt_q, fcnt_d;
  logic            fifo_empty, push, fifo_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Outstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_empty   = (fcnt_q == '0);
  assign bus_rvalid_o = ~fifo_empty | exit_vld;
  assign pop          = bus_rvalid_o & bus_rready_i;
  assign push         = exit_vld & ~(fifo_empty & pop);
  assign fifo_pop     = pop & ~fifo_empty;

  always_comb begin
    fcnt_d = fcnt_q;
    if (push && !fifo_pop) begin
      fcnt_d = fcnt_q + CntW'(1);
    end else if (!push && fifo_pop) begin
      fcnt_d = fcnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < Outstanding; i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      fcnt_q <= fcnt_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= exit_data;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  always_comb begin
    bus_rdata_o = '0;
    if (!fifo_empty) begin
      bus_rdata_o = fifo_data_q[rd_ptr_q];
    end else if (exit_vld) begin
      bus_rdata_o = exit_data;
    end
  end

`ifdef SRAM_ARB_WR_LOCK_EN
  logic [Outstanding-1:0] fifo_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_err_q <= '0;
    end else if (push) begin
      fifo_err_q[wr_ptr_q] <= exit_err;
    end
  end

  always_comb begin
    bus_rerr_o = 1'b0;
    if (!fifo_empty) begin
      bus_rerr_o = fifo_err_q[rd_ptr_q];
    end else if (exit_vld) begin
      bus_rerr_o = exit_err;
    end
  end
`else
  assign bus_rerr_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a driver predicts grants/SRAM pins and queues expected
// responses from a reference memory; a monitor compares responses in order with timing.
module tb_sram_port_arbiter;

  localparam int unsigned AW   = 13;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned LAT  = 2;
  localparam int unsigned OUTS = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          loader_en_i = 1'b0, loader_we_i = 1'b0;
  logic [AW-1:0] loader_addr_i = '0;
  logic [DW-1:0] loader_wdata_i = '0;
  logic          bus_req_i = 1'b0, bus_gnt_o, bus_we_i = 1'b0;
  logic [AW-1:0] bus_addr_i = '0;
  logic [DW-1:0] bus_wdata_i = '0;
  logic [BW-1:0] bus_be_i = '0;
  logic          bus_rvalid_o, bus_rready_i = 1'b0;
  logic [DW-1:0] bus_rdata_o;
  logic          lock_i = 1'b0, bus_rerr_o;
  logic          csb_o, we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [BW-1:0] wmask_o;
  logic [DW-1:0] rdata_i;

  always #5 clk_i = ~clk_i;

  sram_port_arbiter #(.AW(AW), .DW(DW), .RdLatency(LAT), .Outstanding(OUTS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .loader_en_i(loader_en_i), .loader_we_i(loader_we_i),
    .loader_addr_i(loader_addr_i), .loader_wdata_i(loader_wdata_i),
    .bus_req_i(bus_req_i), .bus_gnt_o(bus_gnt_o), .bus_we_i(bus_we_i),
    .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_be_i(bus_be_i),
    .bus_rvalid_o(bus_rvalid_o), .bus_rready_i(bus_rready_i), .bus_rdata_o(bus_rdata_o),
    .lock_i(lock_i), .bus_rerr_o(bus_rerr_o),
    .csb_o(csb_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .wmask_o(wmask_o),
    .rdata_i(rdata_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // SRAM macro: data appears LAT cycles after the access; garbage on non-read cycles.
  logic [DW-1:0] sram_mem [2**AW];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk_i) begin
    if (!csb_o && !we_o) begin
      for (int b = 0; b < BW; b++) begin
        if (wmask_o[b]) sram_mem[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
      end
    end
    rd_pipe[0] <= (!csb_o && we_o) ? sram_mem[addr_o] : DW'($urandom);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rdata_i = rd_pipe[LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            gcyc;
  } exp_t;

  exp_t          sbq[$];
  int            last_pop = -100;
  logic [DW-1:0] ref_mem [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus; entered and left at posedge + 1.
  task automatic drive(input logic len, input logic lwe, input logic [AW-1:0] la,
                       input logic [DW-1:0] ld, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be,
                       input logic rr, input logic lk);
    logic          e_gnt, e_lock, e_csb, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_mask;
    exp_t          ent;
    loader_en_i = len; loader_we_i = lwe; loader_addr_i = la; loader_wdata_i = ld;
    bus_req_i = req; bus_we_i = we; bus_addr_i = a; bus_wdata_i = d; bus_be_i = be;
    bus_rready_i = rr; lock_i = lk;
    #1;
    e_gnt = req && !len && (sbq.size() < OUTS);
`ifdef SRAM_ARB_WR_LOCK_EN
    e_lock = e_gnt && we && lk;
`else
    e_lock = 1'b0;
`endif
    e_csb = 1'b1; e_we = 1'b1; e_addr = '0; e_wdata = '0; e_mask = '0;
    if (len && lwe) begin
      e_csb = 1'b0; e_we = 1'b0; e_addr = la; e_wdata = ld; e_mask = '1;
    end else if (e_gnt && !e_lock) begin
      e_csb = 1'b0; e_we = !we; e_addr = a; e_wdata = d; e_mask = be;
    end
    @(negedge clk_i);
    chk("gnt", bus_gnt_o, e_gnt);
    chk("csb", csb_o, e_csb);
    chk("we", we_o, e_we);
    chk("addr", addr_o, e_addr);
    chk("wdata", wdata_o, e_wdata);
    chk("wmask", wmask_o, e_mask);
    if (e_gnt) begin
      ent.data = we ? '0 : ref_mem[a[5:0]];
      ent.err  = e_lock;
      ent.gcyc = cyc;
      sbq.push_back(ent);
      if (we && !e_lock) begin
        for (int b = 0; b < BW; b++) if (be[b]) ref_mem[a[5:0]][8*b +: 8] = d[8*b +: 8];
      end
    end
    if (len && lwe) ref_mem[la[5:0]] = ld;
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [BW-1:0] be, input logic rr, input logic lk);
    drive(1'b0, 1'b0, '0, '0, 1'b1, we, a, d, be, rr, lk);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, rr, 1'b0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt", bus_gnt_o, 0);
    chk("rst_rvalid", bus_rvalid_o, 0);
    chk("rst_rdata", bus_rdata_o, 0);
    chk("rst_rerr", bus_rerr_o, 0);
    chk("rst_csb", csb_o, 1);
    chk("rst_we", we_o, 1);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wmask", wmask_o, 0);
  endtask

  // Response monitor: in-order; a response may show once its latency has elapsed and its
  // predecessor has been popped.
  initial begin
    int   ready_at;
    logic e_v;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        e_v = 1'b0;
        if (sbq.size() > 0) begin
          ready_at = sbq[0].gcyc + int'(LAT);
          if (last_pop + 1 > ready_at) ready_at = last_pop + 1;
          e_v = (cyc >= ready_at);
        end
        chk("rvalid", bus_rvalid_o, e_v);
        if (e_v && bus_rvalid_o) begin
          chk("rdata", bus_rdata_o, sbq[0].data);
          chk("rerr", bus_rerr_o, sbq[0].err);
          if (bus_rready_i) begin
            void'(sbq.pop_front());
            last_pop = cyc;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic len_r;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_outputs();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Loader preload with a concurrent bus request that must be refused.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b1, 1'b0, AW'(i), '0, '1, 1'b1, 1'b0);
    end
    drive(1'b1, 1'b1, AW'('h010), 32'hDEADBEEF, 1'b1, 1'b0, '0, '0, '1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, AW'('h011), 32'h12345678, 1'b1, 1'b1, '0, '0, '1, 1'b1, 1'b0);

    // Read latency and byte write.
    bus(1'b0, AW'('h010), '0, '1, 1'b1, 1'b0);
    idle(3, 1'b1);
    bus(1'b1, AW'('h004), 32'h00AB0000, 4'b0100, 1'b1, 1'b0);
    idle(3, 1'b1);
    bus(1'b0, AW'('h004), '0, '1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Credit stall, then a single pop frees one credit.
    bus(1'b0, AW'('h010), '0, '1, 1'b0, 1'b0);
    bus(1'b0, AW'('h004), '0, '1, 1'b0, 1'b0);
    repeat (3) bus(1'b0, AW'('h011), '0, '1, 1'b0, 1'b0);
    bus(1'b0, AW'('h011), '0, '1, 1'b1, 1'b0);
    bus(1'b0, AW'('h011), '0, '1, 1'b0, 1'b0);
    idle(4, 1'b0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 12; i++) bus(1'b0, AW'(i), '0, '1, 1'b1, 1'b0);
    idle(4, 1'b1);

`ifdef SRAM_ARB_WR_LOCK_EN
    bus(1'b1, AW'('h020), 32'h11223344, '1, 1'b1, 1'b0);
    bus(1'b1, AW'('h020), 32'hFFFFFFFF, '1, 1'b1, 1'b1);
    bus(1'b0, AW'('h020), '0, '1, 1'b1, 1'b1);
    idle(4, 1'b1);
`endif

    // Randomised traffic, including loader_en toggling with responses in flight.
    len_r = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) len_r = ~len_r;
      drive(len_r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
            AW'($urandom_range(0, 63)), DW'($urandom), BW'($urandom),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset with responses pending discards them.
    idle(3, 1'b1);
    bus(1'b0, AW'('h010), '0, '1, 1'b0, 1'b0);
    bus(1'b0, AW'('h011), '0, '1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    bus_req_i = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs();
    sbq.delete();
    last_pop = -100;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(4, 1'b1);
    bus(1'b0, AW'('h010), '0, '1, 1'b1, 1'b0);

    for (int i = 0; i < 40 && sbq.size() > 0; i++) idle(1, 1'b1);
    chk("drain_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Parametrised successor to the single-port instruction-memory front-end. Shares one single-port SRAM macro between a pipelined bus requester and a boot/loader write port. Adds configurable data width, SRAM read latency, and outstanding-transaction depth, plus a response FIFO with back-pressure. Sits between the TL-UL SRAM adapter (or any req/gnt master) and an OpenRAM-style macro with active-low chip-select and write-enable.

Parameters:
AW, 13, SRAM word-address width
DW, 32, data width; must be a multiple of 8
RdLatency, 1, SRAM read latency in cycles, range 1..4
Outstanding, 2, maximum accepted-but-unreturned bus requests; also response FIFO depth, range 1..8

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
loader_en_i  in  1  1: loader owns the SRAM exclusively
loader_we_i  in  1  loader write strobe
loader_addr_i  in  AW  loader word address
loader_wdata_i  in  DW  loader write data
bus_req_i  in  1  bus request
bus_gnt_o  out  1  bus grant
bus_we_i  in  1  bus write
bus_addr_i  in  AW  bus word address
bus_wdata_i  in  DW  bus write data
bus_be_i  in  DW/8  bus byte enables
bus_rvalid_o  out  1  response valid
bus_rready_i  in  1  response accept
bus_rdata_o  out  DW  read data; 0 for writes
lock_i  in  1  write-lock; used only with the optional feature
bus_rerr_o  out  1  response error; used only with the optional feature
csb_o  out  1  SRAM chip select, active-low
we_o  out  1  SRAM write enable, active-low
addr_o  out  AW  SRAM address
wdata_o  out  DW  SRAM write data
wmask_o  out  DW/8  SRAM byte mask
rdata_i  in  DW  SRAM read data

Behaviour:
- Reset: bus_gnt_o=0, bus_rvalid_o=0, bus_rdata_o=0, bus_rerr_o=0, csb_o=1, we_o=1, addr_o/wdata_o/wmask_o=0. The outstanding counter, latency pipeline and FIFO are all cleared.
- SRAM outputs are combinational from the winner of the current cycle. When idle: csb_o=1, we_o=1, addr_o/wdata_o/wmask_o=0.
- loader_en_i=1:
  - bus_gnt_o=0.
  - A loader_we_i cycle drives csb_o=0, we_o=0, wmask_o all ones, and loader_addr_i/loader_wdata_i.
  - The loader gets no response.
- loader_en_i=0:
  - Loader inputs are ignored.
  - bus_gnt_o = bus_req_i and (cnt < Outstanding).
  - A grant drives the SRAM access in the same cycle: csb_o=0, we_o=~bus_we_i, wmask_o=bus_be_i.
- cnt counts accepted requests not yet popped. It increments on grant and decrements on bus_rvalid_o & bus_rready_i. Both in the same cycle leaves it unchanged. It never exceeds Outstanding.
- Latency pipeline:
  - Every granted bus access enters a RdLatency-deep valid/we/err shift pipeline.
  - At the exit stage, an entry is pushed to the FIFO: rdata_i for reads, 0 for writes.
  - Grant-to-earliest-rvalid latency is RdLatency cycles.
  - Fully pipelined: back-to-back grants are allowed.
- FIFO:
  - Depth Outstanding; the head drives bus_rvalid_o, bus_rdata_o and bus_rerr_o.
  - Push and pop in the same cycle are legal, including when full.
  - Overflow is impossible by credit; none is checked.
  - Order is strictly in-order.
- Toggling loader_en_i mid-flight:
  - In-flight bus responses still drain.
  - Bus requests are refused from the cycle loader_en_i rises.
  - Loader writes take the port immediately; they do not conflict because the SRAM is accessed only in the grant cycle.
- Asynchronous reset mid-operation discards all pending responses.

Optional Feature:
Macro SRAM_ARB_WR_LOCK_EN.
- Defined:
  - A bus write granted while lock_i=1 is not sent to the SRAM (csb_o stays 1).
  - It still consumes a credit and travels the pipeline.
  - Its response has bus_rerr_o=1 and bus_rdata_o=0.
  - Reads, and writes with lock_i=0, return bus_rerr_o=0.
- Undefined:
  - lock_i is ignored and bus_rerr_o is tied 0.
  - The error bit is not stored in the pipeline or FIFO.

Test Plan:
- Loader fill: loader_en_i=1; write 0xDEADBEEF to 0x010 → csb_o=0, we_o=0, wmask_o=0xF that cycle. A concurrent bus_req_i sees bus_gnt_o=0.
- Read latency: loader_en_i=0, RdLatency=2, bus read of 0x010 → bus_rvalid_o exactly 2 cycles after grant, bus_rdata_o=0xDEADBEEF.
- Byte write: bus write to 0x004 with bus_be_i=0b0100, data 0x00AB0000 → wmask_o=0b0100, we_o=0. Write response has rdata=0.
- Credit stall: Outstanding=2, bus_rready_i=0, three back-to-back reads → two grants, third gnt=0. Raising bus_rready_i for one pop → third granted next cycle; responses return in order.
- Simultaneous push/pop: FIFO full, continuous requests, bus_rready_i=1 → one grant per cycle sustained with no lost or duplicated response.
- Lock (SRAM_ARB_WR_LOCK_EN): lock_i=1, bus write to 0x020 → csb_o=1, response bus_rerr_o=1. A following read of 0x020 returns the old data with rerr=0.
